// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a private accumulator and held result register per requester.
module alu_arbiter #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [3:0]        opcode0,
    input  logic [3:0]        opcode1,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] b1,
    output logic [1:0]        ack,
    output logic [2:0]        alu_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_y,
    output logic [1:0]        done,
    output logic              err,
    output logic [DATA_W-1:0] result0,
    output logic [DATA_W-1:0] result1,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_g;
    logic              r_last;
    logic [DATA_W-1:0] r_acc0;
    logic [DATA_W-1:0] r_acc1;
    logic [1:0]        r_ack;
    logic [1:0]        r_done;
    logic              r_err;
    logic [DATA_W-1:0] r_result0;
    logic [DATA_W-1:0] r_result1;

    logic              w_win;
    logic              w_legal;
    logic              w_use_acc;
    logic [DATA_W-1:0] w_acc_g;

    // On contention the requester that did not win last time gets the grant.
    assign w_win     = (&req) ? ~r_last : req[1];
    assign w_legal   = (r_op <= 4'd8);
    assign w_use_acc = r_op[0] & ~r_op[3];
    assign w_acc_g   = r_g ? r_acc1 : r_acc0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        alu_sel = '0;
        alu_a   = '0;
        alu_b   = '0;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next = S_DONE;
                if (w_legal) begin
                    alu_sel = r_op[3] ? 3'b100 : {1'b0, r_op[2:1]};
                    alu_a   = w_use_acc ? w_acc_g : r_a;
                    alu_b   = r_b;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_g       <= 1'b0;
            r_last    <= 1'b1;
            r_acc0    <= '0;
            r_acc1    <= '0;
            r_ack     <= '0;
            r_done    <= '0;
            r_err     <= 1'b0;
            r_result0 <= '0;
            r_result1 <= '0;
        end else begin
            r_ack  <= '0;
            r_done <= '0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_op   <= w_win ? opcode1 : opcode0;
                        r_a    <= w_win ? a1 : a0;
                        r_b    <= w_win ? b1 : b0;
                        r_g    <= w_win;
                        r_last <= w_win;
                        r_ack  <= w_win ? 2'b10 : 2'b01;
                    end
                end
                S_EXEC: begin
                    r_done <= r_g ? 2'b10 : 2'b01;
                    if (!w_legal) begin
                        r_err <= 1'b1;
                    end else if (r_g) begin
                        r_acc1    <= alu_y;
                        r_result1 <= alu_y;
                    end else begin
                        r_acc0    <= alu_y;
                        r_result0 <= alu_y;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ack     = r_ack;
    assign done    = r_done;
    assign err     = r_err;
    assign result0 = r_result0;
    assign result1 = r_result1;
    assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 8-bit ALU on alu_y.
module tb_alu_arbiter;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic [3:0] opcode0, opcode1;
    logic [7:0] a0, a1, b0, b1;
    logic [1:0] ack;
    logic [2:0] alu_sel;
    logic [7:0] alu_a, alu_b, alu_y;
    logic [1:0] done;
    logic       err;
    logic [7:0] result0, result1;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;

    alu_arbiter #(.DATA_W(8)) dut (
        .clk(clk), .reset(reset), .req(req),
        .opcode0(opcode0), .opcode1(opcode1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .ack(ack), .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
        .alu_y(alu_y), .done(done), .err(err),
        .result0(result0), .result1(result1), .busy(busy)
    );

    always_comb begin
        case (alu_sel)
            3'b000:  alu_y = alu_a + alu_b;
            3'b001:  alu_y = alu_a - alu_b;
            3'b010:  alu_y = alu_a & alu_b;
            3'b011:  alu_y = alu_a | alu_b;
            3'b100:  alu_y = alu_a >> alu_b[2:0];
            default: alu_y = 8'h00;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    // Issue one instruction from requester r and follow it back to IDLE.
    task automatic run(input string tag, input bit r, input logic [3:0] op,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_res, input logic exp_err);
        logic [1:0] oh;
        oh = r ? 2'b10 : 2'b01;
        if (r) begin
            opcode1 = op; a1 = a; b1 = b;
        end else begin
            opcode0 = op; a0 = a; b0 = b;
        end
        req = oh;
        step();
        chk({tag, "_ack"}, 32'(ack), 32'(oh));
        req = 2'b00;
        step();
        chk({tag, "_done"}, 32'(done), 32'(oh));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_res"}, 32'(r ? result1 : result0), 32'(exp_res));
        step();
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b0; req = 2'b00;
        opcode0 = 4'h0; opcode1 = 4'h0;
        a0 = 8'h00; a1 = 8'h00; b0 = 8'h00; b1 = 8'h00;
        #2;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sel", 32'(alu_sel), 32'd0);
        chk("rst_res0", 32'(result0), 32'd0);
        chk("rst_res1", 32'(result1), 32'd0);
        step();
        step();
        reset = 1'b1;

        // Single add with cycle-by-cycle checks
        opcode0 = 4'h0; a0 = 8'h05; b0 = 8'h03; req = 2'b01;
        step();
        chk("add_ack", 32'(ack), 32'h1);
        chk("add_busy", 32'(busy), 32'd1);
        chk("add_sel", 32'(alu_sel), 32'h0);
        chk("add_a", 32'(alu_a), 32'h05);
        chk("add_b", 32'(alu_b), 32'h03);
        chk("add_nodone", 32'(done), 32'd0);
        req = 2'b00; a0 = 8'hAA;
        step();
        chk("add_done", 32'(done), 32'h1);
        chk("add_err", 32'(err), 32'd0);
        chk("add_res0", 32'(result0), 32'h08);
        chk("add_ack_clr", 32'(ack), 32'd0);
        chk("add_alua_done", 32'(alu_a), 32'd0);
        step();
        chk("add_idle", 32'(busy), 32'd0);
        chk("add_done_clr", 32'(done), 32'd0);

        // Context isolation
        do_reset();
        run("iso1a", 1'b1, 4'h1, 8'h00, 8'h10, 8'h10, 1'b0);
        run("iso1b", 1'b1, 4'h1, 8'h00, 8'h10, 8'h20, 1'b0);
        run("iso0", 1'b0, 4'h1, 8'h00, 8'h01, 8'h01, 1'b0);
        chk("iso_res1_held", 32'(result1), 32'h20);

        // Wrap-around
        run("wadd", 1'b0, 4'h0, 8'hF0, 8'h20, 8'h10, 1'b0);
        run("wsub", 1'b0, 4'h2, 8'h03, 8'h05, 8'hFE, 1'b0);
        run("wadda", 1'b0, 4'h1, 8'h00, 8'h02, 8'h00, 1'b0);

        // Other opcodes on requester 1
        run("shr", 1'b1, 4'h8, 8'h80, 8'h03, 8'h10, 1'b0);
        run("or_a", 1'b1, 4'h7, 8'hEE, 8'h03, 8'h13, 1'b0);
        run("sub_a", 1'b1, 4'h3, 8'hEE, 8'h14, 8'hFF, 1'b0);
        run("and_a", 1'b1, 4'h5, 8'hEE, 8'h0F, 8'h0F, 1'b0);

        // Illegal opcode leaves result and accumulator alone
        run("pre_ill", 1'b0, 4'h1, 8'h00, 8'h05, 8'h05, 1'b0);
        opcode0 = 4'hA; a0 = 8'h33; b0 = 8'h44; req = 2'b01;
        step();
        chk("ill_ack", 32'(ack), 32'h1);
        chk("ill_sel", 32'(alu_sel), 32'd0);
        chk("ill_a", 32'(alu_a), 32'd0);
        chk("ill_b", 32'(alu_b), 32'd0);
        req = 2'b00;
        step();
        chk("ill_done", 32'(done), 32'h1);
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_res0", 32'(result0), 32'h05);
        step();
        chk("ill_err_clr", 32'(err), 32'd0);
        run("post_ill", 1'b0, 4'h1, 8'h00, 8'h01, 8'h06, 1'b0);

        // Contention: continuous dual request alternates 0,1,0,1
        do_reset();
        opcode0 = 4'h0; a0 = 8'h01; b0 = 8'h01;
        opcode1 = 4'h0; a1 = 8'h02; b1 = 8'h02;
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("cont_ack", 32'(ack), (k % 2 == 1) ? 32'h2 : 32'h1);
            chk("cont_busy_e", 32'(busy), 32'd1);
            if (k == 3) req = 2'b00;
            step();
            chk("cont_done", 32'(done), (k % 2 == 1) ? 32'h2 : 32'h1);
            chk("cont_busy_d", 32'(busy), 32'd1);
            step();
            chk("cont_idle", 32'(busy), 32'd0);
            chk("cont_ack_clr", 32'(ack), 32'd0);
        end
        chk("cont_res0", 32'(result0), 32'h02);
        chk("cont_res1", 32'(result1), 32'h04);

        // Reset during EXEC discards the in-flight instruction
        opcode0 = 4'h1; a0 = 8'h00; b0 = 8'h40; req = 2'b01;
        step();
        chk("rx_ack", 32'(ack), 32'h1);
        reset = 1'b0;
        #1;
        chk("rx_ack0", 32'(ack), 32'd0);
        chk("rx_busy0", 32'(busy), 32'd0);
        chk("rx_alua0", 32'(alu_a), 32'd0);
        chk("rx_res0", 32'(result0), 32'd0);
        chk("rx_res1", 32'(result1), 32'd0);
        opcode0 = 4'h1; a0 = 8'h00; b0 = 8'h03;
        opcode1 = 4'h0; a1 = 8'h09; b1 = 8'h09;
        req = 2'b11;
        #1;
        reset = 1'b1;
        step();
        chk("rx_nodone", 32'(done), 32'd0);
        chk("rx_first", 32'(ack), 32'h1);
        req = 2'b00;
        step();
        chk("rx_done", 32'(done), 32'h1);
        chk("rx_acc_clr", 32'(result0), 32'h03);
        step();
        chk("rx_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

- Shares the single 8-bit ALU datapath between two instruction requesters (requester 0 and requester 1).
- Uses round-robin arbitration.
- Latches the winning requester's opcode and operands, then drives the ALU for one execute cycle.
- Keeps a private accumulator per requester, so accumulate-form opcodes never see the other requester's state.
- Sits between the instruction sources (program controller, host/debug port) and the ALU; it replaces direct controller-to-ALU wiring.

## Interface

Parameters:
- DATA_W, 8, operand, accumulator and result width

Ports:
- clk  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-low; 0 resets all state immediately
- req  input  2  req[i] high = requester i presents a valid instruction
- opcode0, opcode1  input  4 each  instruction opcode per requester
- a0, a1  input  DATA_W each  operand A per requester
- b0, b1  input  DATA_W each  operand B per requester
- ack  output  2  ack[i] one-cycle pulse: requester i's instruction accepted
- alu_sel  output  3  ALU operation select: 000 add, 001 sub, 010 and, 011 or, 100 shr
- alu_a, alu_b  output  DATA_W each  ALU operands
- alu_y  input  DATA_W  combinational ALU result
- done  output  2  done[i] one-cycle pulse: requester i's instruction completed
- err  output  1  high with done when the completed opcode was illegal
- result0, result1  output  DATA_W each  last result per requester, held between operations
- busy  output  1  high whenever state is not IDLE

## Operation

**States:** IDLE, EXEC, DONE. Reset state is IDLE.

**Reset values:**
- All outputs 0.
- Accumulators acc0 and acc1 = 0.
- Internal last_grant = 1, so requester 0 wins the first contention.

**IDLE**
- If req == 00, stay in IDLE.
- Otherwise pick winner w:
  - only one req high: that requester wins;
  - both high: the requester ≠ last_grant wins.
- On the clock edge:
  - latch opcode_w, a_w and b_w into internal registers;
  - g ← w, last_grant ← w;
  - ack[w] ← 1;
  - go to EXEC.

**EXEC**
- ack[g] is high for this cycle only.
- Outputs are driven combinationally from the latched registers:
  - 0000 add: alu_sel 000, alu_a = A, alu_b = B
  - 0001 add_a: alu_sel 000, alu_a = acc_g, alu_b = B
  - 0010 sub / 0011 sub_a: alu_sel 001, same A/acc_g selection as add / add_a
  - 0100 and / 0101 and_a: alu_sel 010, same selection
  - 0110 or / 0111 or_a: alu_sel 011, same selection
  - 1000 shr: alu_sel 100, alu_a = A, alu_b = B
  - 1001–1111 illegal: alu_sel, alu_a, alu_b = 0
- On the clock edge:
  - legal opcode: acc_g ← alu_y and result_g ← alu_y;
  - illegal opcode: acc_g and result_g unchanged, err ← 1;
  - done[g] ← 1;
  - go to DONE.

**DONE**
- done[g] high for this cycle only; err is valid alongside it.
- On the clock edge: done and err clear, go to IDLE.

**Outside EXEC:** alu_sel, alu_a and alu_b are 0.

**Arithmetic:** all results are DATA_W bits with carry/borrow discarded. The ALU wraps; the arbiter never widens.

**Requester rules:**
- Hold req and the instruction fields stable until ack is seen.
- Fields may change in the ack cycle.
- A req still high in a later IDLE cycle is a new instruction.
- The arbiter samples req only in IDLE; a req raised during EXEC or DONE waits.

**Reset mid-operation:**
- The in-flight instruction is discarded: no done and no accumulator update.
- Accumulators clear to 0.

## Timing

- Request sampled at the end of IDLE cycle n.
- ack at cycle n+1 (EXEC).
- done, err and updated result_g visible at cycle n+2 (DONE).
- Back in IDLE at n+3.
- Latency from sample to done: 2 cycles. Throughput: one instruction per 3 cycles.
- Under continuous dual requests the grants alternate 0, 1, 0, 1, … with no starvation. The maximum wait is one foreign instruction (3 cycles).
- result0 and result1 change only on the EXEC→DONE edge of their own requester's legal instruction.

## Test plan

- **Single add:** after reset, req=01, opcode0=0000, a0=0x05, b0=0x03 → ack=01 at n+1 with alu_sel=000, alu_a=0x05, alu_b=0x03; done=01, result0=0x08, err=0 at n+2.
- **Contention:** req=11 held continuously → grant order 0, 1, 0, 1; ack pulses every 3 cycles, alternating; busy low only for the IDLE cycle between grants.
- **Context isolation:** requester 1 issues add_a with b1=0x10 twice → result1 0x10 then 0x20; requester 0's add_a with b0=0x01 → result0=0x01 (acc0 untouched by requester 1).
- **Wrap-around:** add 0xF0+0x20 → 0x10; sub 0x03−0x05 → 0xFE; next add_a with B=0x02 on the same requester → 0x00.
- **Illegal opcode 1010:** ack, then done with err=1; alu_sel, alu_a and alu_b = 0 during EXEC; result and accumulator unchanged.
- **Reset during EXEC:** assert reset=0 in the EXEC cycle → all outputs 0 immediately, no done pulse; after release with req=11, requester 0 is granted first.
